m68k_gpio_target: RTL

- Bus responder (target) for the fx68k asynchronous 68000 bus. Answers CPU-initiated cycles with a registered DTACK after a programmable number of wait states.
- Owns a 16-bit GPIO register file: port A is the upper byte, port B is the lower byte. Provides direction control, synchronized pin inputs, rising-edge capture and a level IRQ.
- Sits beside RAM/ROM. It is selected by an externally decoded chip select and replaces the top level's fixed DTACK for its address range.

---
 rtl/m68k_bus_pkg.sv | 19 +
 rtl/bus_ack_fsm.sv | 99 +++++++++
 rtl/m68k_gpio_target.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus responder: register indices,
// bus FSM state encoding and wait-counter width.
package m68k_bus_pkg;

  localparam int WAIT_W = 4;

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_DIR  = 3'd1;
  localparam logic [2:0] REG_PIN  = 3'd2;
  localparam logic [2:0] REG_EDGE = 3'd3;
  localparam logic [2:0] REG_MASK = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_ack_fsm.sv
// 68000 target-side bus control: counts wait states, raises a one-cycle access
// strobe on ACK entry, and holds DTACK until the CPU drops AS.
// Handshake: a cycle opens when cs & !as_n & a data strobe is low in IDLE; dtack_n
// goes low on ACK entry and stays low until as_n is sampled high; as_n high in
// WAIT abandons the cycle without an access or DTACK.
module bus_ack_fsm
  import m68k_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cs_i,
  input  logic             as_n_i,
  input  logic             uds_n_i,
  input  logic             lds_n_i,
  input  logic             rw_i,
  input  logic [2:0]       addr_i,
  output logic             dtack_n_o,
  output logic             acc_o,
  output logic [2:0]       idx_o,
  output logic             rw_o,
  output logic [1:0]       lanes_o,
  output bus_state_e       state_o
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

  bus_state_e        state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [2:0]        idx_q;
  logic              rw_q;
  logic [1:0]        lanes_q;
  logic              dtack_n_q;
  logic              start;

  assign start = cs_i & ~as_n_i & (~uds_n_i | ~lds_n_i);

  always_comb begin
    acc_o = 1'b0;
    case (state_q)
      ST_IDLE: acc_o = start && (WAIT_STATES == 0);
      ST_WAIT: acc_o = ~as_n_i && (cnt_q == '0);
      default: acc_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      rw_q      <= 1'b1;
      lanes_q   <= '0;
      dtack_n_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q   <= addr_i;
            rw_q    <= rw_i;
            lanes_q <= {~uds_n_i, ~lds_n_i};
            cnt_q   <= WAIT_LOAD;
            if (WAIT_STATES == 0) begin
              state_q   <= ST_ACK;
              dtack_n_q <= 1'b0;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (as_n_i) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            state_q   <= ST_ACK;
            dtack_n_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ACK: begin
          if (as_n_i) begin
            state_q   <= ST_IDLE;
            dtack_n_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dtack_n_o = dtack_n_q;
  assign idx_o     = idx_q;
  assign rw_o      = rw_q;
  assign lanes_o   = lanes_q;
  assign state_o   = state_q;

endmodule

// File: rtl/m68k_gpio_target.sv
// GPIO register file behind a 68000 bus responder: DATA/DIR outputs,
// synchronized pin inputs, rising-edge capture with a masked level IRQ.
module m68k_gpio_target
  import m68k_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        rw,
  input  logic [2:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        dtack_n,
  input  logic [15:0] pin_in,
  output logic [15:0] pin_out,
  output logic [15:0] pin_oe,
  output logic        irq
);

  logic        acc;
  logic [2:0]  cap_idx;
  logic        cap_rw;
  logic [1:0]  cap_lanes;
  bus_state_e  fsm_state;

  bus_ack_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk_i    (clk),
    .rst_i    (rst),
    .cs_i     (cs),
    .as_n_i   (as_n),
    .uds_n_i  (uds_n),
    .lds_n_i  (lds_n),
    .rw_i     (rw),
    .addr_i   (addr),
    .dtack_n_o(dtack_n),
    .acc_o    (acc),
    .idx_o    (cap_idx),
    .rw_o     (cap_rw),
    .lanes_o  (cap_lanes),
    .state_o  (fsm_state)
  );

  // With zero wait states the access fires from IDLE, before the capture registers load.
  logic        in_idle;
  logic [2:0]  a_idx;
  logic        a_rw;
  logic [1:0]  a_lanes;
  logic [15:0] lane_mask;
  logic        wr;

  assign in_idle   = (fsm_state == ST_IDLE);
  assign a_idx     = in_idle ? addr : cap_idx;
  assign a_rw      = in_idle ? rw : cap_rw;
  assign a_lanes   = in_idle ? {~uds_n, ~lds_n} : cap_lanes;
  assign lane_mask = {{8{a_lanes[1]}}, {8{a_lanes[0]}}};
  assign wr        = acc & ~a_rw;

  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] prev_q;
  logic [15:0] pin_sync;
  logic [15:0] edge_set;

  assign pin_sync = sync_q[SYNC_STAGES-1];
  assign edge_set = pin_sync & ~prev_q;

  logic [15:0] data_q, data_d;
  logic [15:0] dir_q, dir_d;
  logic [15:0] edge_q, edge_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] dout_q, dout_d;
  logic        irq_q;
  logic [15:0] edge_clr;
  logic [15:0] rd_val;

  always_comb begin
    data_d   = data_q;
    dir_d    = dir_q;
    mask_d   = mask_q;
    edge_clr = '0;
    rd_val   = '0;
    case (a_idx)
      REG_DATA: begin
        rd_val = data_q;
        if (wr) data_d = (data_q & ~lane_mask) | (din & lane_mask);
      end
      REG_DIR: begin
        rd_val = dir_q;
        if (wr) dir_d = (dir_q & ~lane_mask) | (din & lane_mask);
      end
      REG_PIN:  rd_val = pin_sync;
      REG_EDGE: begin
        rd_val = edge_q;
        if (wr) edge_clr = din & lane_mask;
      end
      REG_MASK: begin
        rd_val = mask_q;
        if (wr) mask_d = (mask_q & ~lane_mask) | (din & lane_mask);
      end
      default: rd_val = '0;
    endcase
    // A fresh edge outranks a same-cycle clear so no event is lost.
    edge_d = (edge_q & ~edge_clr) | edge_set;
    dout_d = (acc & a_rw) ? rd_val : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      data_q <= '0;
      dir_q  <= '0;
      edge_q <= '0;
      mask_q <= '0;
      dout_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      sync_q[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= pin_sync;
      data_q <= data_d;
      dir_q  <= dir_d;
      edge_q <= edge_d;
      mask_q <= mask_d;
      dout_q <= dout_d;
      irq_q  <= |(edge_q & mask_q);
    end
  end

  assign dout    = dout_q;
  assign pin_out = data_q;
  assign pin_oe  = dir_q;
  assign irq     = irq_q;

endmodule
